// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Carries ovf only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
   parameter int BIT = 8
);
   logic           start;
   logic [BIT-1:0] a;
   logic [BIT-1:0] b;
   logic           bin;
   logic           ready;
   logic           busy;
   logic           done;
   logic [BIT-1:0] diff;
   logic           bout;
`ifdef SERIAL_SUB_OVF_EN
   logic           ovf;
`endif

   modport master (
      output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
      input  ovf,
`endif
      input  ready, busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
      output ovf,
`endif
      output ready, busy, done, diff, bout
   );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin using one full-subtractor cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
   parameter int BIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   serial_sub_if.slave bus
);
   localparam int CW = $clog2(BIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Returns {difference bit, borrow out} of a single full subtractor.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      full_sub = {x ^ y ^ bi, (~x & y) | (~(x ^ y) & bi)};
   endfunction

   state_t         state_r;
   logic [CW-1:0]  count_r;
   logic           borrow_r;
   logic [BIT-1:0] a_sr_r;
   logic [BIT-1:0] b_sr_r;
   logic [BIT-2:0] res_sr_r;
   logic [BIT-1:0] diff_r;
   logic           bout_r;
   logic           ready_r;
   logic           busy_r;
   logic           done_r;
`ifdef SERIAL_SUB_OVF_EN
   logic           ovf_r;
`endif

   logic [1:0]     fs_s;
   logic [BIT-1:0] res_next_s;
   logic           last_s;

   // The final bit is merged combinationally, so the result register only keeps BIT-1 bits.
   assign fs_s       = full_sub(a_sr_r[0], b_sr_r[0], borrow_r);
   assign res_next_s = {fs_s[1], res_sr_r};
   assign last_s     = (count_r == CW'(BIT - 1));

   // Control FSM and datapath; handshake flags are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         count_r  <= '0;
         borrow_r <= 1'b0;
         a_sr_r   <= '0;
         b_sr_r   <= '0;
         res_sr_r <= '0;
         diff_r   <= '0;
         bout_r   <= 1'b0;
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_r    <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  a_sr_r   <= bus.a;
                  b_sr_r   <= bus.b;
                  borrow_r <= bus.bin;
                  count_r  <= '0;
                  state_r  <= SHIFT;
                  ready_r  <= 1'b0;
                  busy_r   <= 1'b1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            SHIFT: begin
               res_sr_r <= res_next_s[BIT-1:1];
               borrow_r <= fs_s[0];
               a_sr_r   <= {1'b0, a_sr_r[BIT-1:1]};
               b_sr_r   <= {1'b0, b_sr_r[BIT-1:1]};
               count_r  <= count_r + CW'(1);
               if (last_s) begin
                  diff_r  <= res_next_s;
                  bout_r  <= fs_s[0];
`ifdef SERIAL_SUB_OVF_EN
                  // borrow_r here is the borrow into the MSB
                  ovf_r   <= borrow_r ^ fs_s[0];
`endif
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= SHIFT;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               ready_r <= 1'b1;
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready = ready_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.diff  = diff_r;
   assign bus.bout  = bout_r;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf   = ovf_r;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed scenarios plus randomized operands
// compared against an integer-arithmetic reference model.
module tb_serial_sub;
   localparam int BIT = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   serial_sub_if #(.BIT(BIT)) bus ();
   serial_sub #(.BIT(BIT)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain integer subtraction, unsigned and signed views.
   task automatic ref_model(input int a, input int b, input int bi,
                            output logic [BIT-1:0] d, output logic bo, output logic ov);
      int r, sa, sb, rs;
      r  = a - b - bi;
      bo = (r < 0);
      d  = BIT'(r);
      sa = (a >= 2**(BIT-1)) ? a - 2**BIT : a;
      sb = (b >= 2**(BIT-1)) ? b - 2**BIT : b;
      rs = sa - sb - bi;
      ov = (rs < -(2**(BIT-1))) || (rs > 2**(BIT-1) - 1);
   endtask

   task automatic do_op(input logic [BIT-1:0] a, input logic [BIT-1:0] b, input logic bi,
                        input string tag);
      logic [BIT-1:0] exp_d;
      logic           exp_bo, exp_ov, seen;
      int             lat, busy_cnt;
      ref_model(int'(a), int'(b), int'(bi), exp_d, exp_bo, exp_ov);
      @(negedge clk);
      for (int i = 0; i < 4*BIT && !bus.ready; i++) @(negedge clk);
      check({tag, ".ready"}, 32'(bus.ready), 32'd1);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bi;
      @(negedge clk);
      bus.start = 1'b0; bus.a = BIT'($urandom); bus.b = BIT'($urandom); bus.bin = 1'($urandom);
      busy_cnt = 0;
      seen = 1'b0;
      for (lat = 0; lat <= 4*BIT; lat++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cnt++;
         @(negedge clk);
      end
      check({tag, ".done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, ".latency"}, 32'(lat), 32'(BIT));
         check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(BIT));
         check({tag, ".diff"}, 32'(bus.diff), 32'(exp_d));
         check({tag, ".bout"}, 32'(bus.bout), 32'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
         check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ov));
`endif
         @(negedge clk);
         check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
         check({tag, ".ready_after"}, 32'(bus.ready), 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done, last_t;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.ready", 32'(bus.ready), 32'd1);
      check("rst.busy",  32'(bus.busy),  32'd0);
      check("rst.done",  32'(bus.done),  32'd0);
      check("rst.diff",  32'(bus.diff),  32'd0);
      check("rst.bout",  32'(bus.bout),  32'd0);

      // start held while rst is high across an edge must not be accepted
      bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd4;
      @(posedge clk);
      #1 rst = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      check("rst_start.ready", 32'(bus.ready), 32'd1);
      check("rst_start.busy",  32'(bus.busy),  32'd0);

      do_op(8'd100, 8'd37, 1'b0, "basic");
      do_op(8'd5,   8'd9,  1'b0, "wrap1");
      do_op(8'd0,   8'd0,  1'b1, "wrap2");
      do_op(8'd255, 8'd255, 1'b0, "wrap3");

      // start pulses during SHIFT and DONE are ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd1; bus.bin = 1'b0;
      @(negedge clk);
      n_done = 0;
      for (int t = 0; t < 3*BIT; t++) begin
         if (bus.done) begin
            n_done++;
            check("guard.diff", 32'(bus.diff), 32'd199);
            bus.start = 1'b1; bus.a = 8'd10; bus.b = 8'd10;
         end else if (t == 3) begin
            bus.start = 1'b1; bus.a = 8'd10; bus.b = 8'd10;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("guard.n_done", 32'(n_done), 32'd1);
      check("guard.diff_hold", 32'(bus.diff), 32'd199);
      check("guard.idle", 32'(bus.ready), 32'd1);
      do_op(8'd10, 8'd10, 1'b0, "guard_after");

      // reset mid-operation discards the partial result
      do_op(8'd200, 8'd1, 1'b0, "pre_rst");
      bus.start = 1'b1; bus.a = 8'd123; bus.b = 8'd45;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst.ready", 32'(bus.ready), 32'd1);
      check("midrst.busy",  32'(bus.busy),  32'd0);
      check("midrst.done",  32'(bus.done),  32'd0);
      check("midrst.diff",  32'(bus.diff),  32'd0);
      check("midrst.bout",  32'(bus.bout),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int t = 0; t < 2*BIT; t++) begin
         if (bus.done) n_done++;
         @(negedge clk);
      end
      check("midrst.no_done", 32'(n_done), 32'd0);
      do_op(8'd50, 8'd20, 1'b0, "post_rst");

      // start held high: back-to-back operations every BIT+2 cycles
      bus.start = 1'b1; bus.a = 8'd7; bus.b = 8'd3; bus.bin = 1'b0;
      n_done = 0;
      last_t = -1;
      for (int t = 0; t < 6*(BIT+2); t++) begin
         @(negedge clk);
         if (bus.done) begin
            n_done++;
            check("b2b.diff", 32'(bus.diff), 32'd4);
            if (last_t >= 0) check("b2b.interval", 32'(t - last_t), 32'(BIT + 2));
            last_t = t;
         end else if (n_done > 0) begin
            check("b2b.stable", 32'(bus.diff), 32'd4);
         end
      end
      bus.start = 1'b0;
      check("b2b.count", 32'(n_done >= 5), 32'd1);
      for (int i = 0; i < 4*BIT && !bus.ready; i++) @(negedge clk);
      check("b2b.drain", 32'(bus.ready), 32'd1);

      do_op(8'h80, 8'h01, 1'b0, "ovf1");
      do_op(8'h10, 8'h01, 1'b0, "ovf2");

      for (int i = 0; i < 40; i++)
         do_op(BIT'($urandom), BIT'($urandom), 1'($urandom), "rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
